sa_cache_ctrl: RTL and testbench
================================

# sa_cache_ctrl

Controller FSM for the 2-way set-associative, write-back, write-allocate cache between the CPU and the 1M x 16 secondary memory. Holds the tag/state array (`cache_table_type`) and the 16-bit data array, services CPU requests (`cpu_to_cache_type` / `cache_to_cpu_type`) and sequences line write-back and refill over the memory channel (`cache_to_mem_type` / `mem_to_cache_type`). All types come from `cache_definition`.

## Interface
- No parameters. Geometry is fixed:
  - 2 ways, 1024 sets, 1 word per line.
  - index = addr[9:0], tag = addr[19:10].
  - 1-bit LRU per way entry.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_req` input `cpu_to_cache_type`: CPU request.
- `cache_res` output `cache_to_cpu_type`: CPU response.
- `mem_req` output `cache_to_mem_type`: secondary-memory request.
- `mem_res` input `mem_to_cache_type`: secondary-memory response.

## Operation
- **States:** IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- **IDLE**
  - If `cpu_req.valid`=1, latch addr, data and rw into the request register and go to COMPARE.
  - `cpu_req.valid` is ignored in every other state.
- **Hit/miss in COMPARE**
  - Hit in way w when way w is valid and its tag equals the request tag.
- **COMPARE, hit**
  - Read: register `cache_res.data` = way w data.
  - Write: way w data = request data; set way w dirty.
  - LRU update: way w LRU = 0, other way LRU = 1.
  - Pulse `cache_res.ready` and return to IDLE.
- **COMPARE, miss: victim selection**
  - Victim = way 0 if invalid.
  - Else way 1 if invalid.
  - Else the way with LRU=1.
  - If both LRU bits are equal, victim = way 0.
- **COMPARE, miss: next state**
  - Victim valid and dirty: go to WRITE_BACK.
  - Otherwise: go to ALLOCATE.
- **WRITE_BACK**
  - `mem_req` = {addr = {victim tag, index}, data = victim data, rw = 1, valid = 1}.
  - On `mem_res.ready`=1, go to ALLOCATE.
- **ALLOCATE**
  - `mem_req` = {addr = request addr, rw = 0, valid = 1}.
  - On `mem_res.ready`=1, write `mem_res.data` into the victim way.
  - Set the victim's tag = request tag, valid = 1, dirty = 0.
  - Go to COMPARE. The re-compare always hits and completes the request as above, including the write-miss data merge and the dirty bit.
- **`cache_res.stopped`:** 1 while in WRITE_BACK or ALLOCATE, else 0.
- **Request register:** holds its value from capture until the next capture.

## Timing
- **Reset:** on `rst`=1 at an edge, every output and internal bit is cleared.
  - State = IDLE.
  - All valid, dirty and LRU bits = 0. Data and tag contents are don't-care.
  - `cache_res` = {data 0, ready 0, stopped 0}.
  - `mem_req` = {addr 0, data 0, rw 0, valid 0}.
- **Reset mid-operation:** aborts the operation.
  - `mem_req.valid` is 0 from the first post-reset cycle.
  - No array write occurs on the reset edge.
  - Dirty data in flight is discarded.
- **Registered outputs:** all outputs are registered.
- **Hit latency:** valid sampled at edge N, COMPARE at edge N+1, `ready` high during cycle N+1→N+2. Hit latency is therefore 2 edges from sampling.
- **`cache_res.ready`:** exactly one cycle wide.
- **`cache_res.data`:** holds until the next read hit.
- **CPU protocol:**
  - `valid` is a one-cycle pulse.
  - The next request is issued no earlier than the cycle `ready` is high.
  - A request arriving in the `ready` cycle is accepted (back-to-back).
- **Memory handshake:**
  - `mem_req` fields are stable and `valid` is held until the edge that samples `mem_res.ready`=1.
  - The next state takes effect at that edge. Between WRITE_BACK and ALLOCATE, `valid` stays 1 and the fields change.
  - `mem_req.valid` returns to 0 when entering COMPARE.
  - `mem_res.ready` outside WRITE_BACK/ALLOCATE is ignored.
  - Memory latency is unbounded. Ready on the first cycle of `valid` (zero wait) is legal.
- **Miss latency:** 2 + Wwb + Wal + 1 edges to `ready`, where Wwb and Wal are the memory wait cycles of each phase, counting the ready edge.

## Test plan
- **Cold read miss:** reset, read 0x00005, memory returns 0xBEEF after 3 wait cycles.
  - One ALLOCATE at addr 0x00005 and no WRITE_BACK.
  - `ready` pulse with data 0xBEEF.
  - `stopped` high only during ALLOCATE.
- **Read hit:** repeat read 0x00005.
  - `ready`/0xBEEF 2 edges after valid.
  - `mem_req.valid` stays 0.
- **Write miss and dirty eviction:**
  - Write 0x00405←0x1234: allocates way 1, dirty.
  - Read 0x00805: way 0 is LRU and clean, no write-back.
  - Read 0x00C05: WRITE_BACK addr 0x00405 data 0x1234, then ALLOCATE 0x00C05.
- **Memory latency extremes:**
  - Zero-wait memory: total miss latency 4 edges without write-back, 5 with write-back.
  - 20-wait memory: `mem_req` held stable for all 20 cycles.
- **Reset mid-operation:** reset asserted during WRITE_BACK.
  - `mem_req.valid`=0 in the next cycle and all outputs are at reset values.
  - A later read of 0x00405 misses.
- **Protocol robustness:**
  - `cpu_req.valid` pulsed during ALLOCATE is ignored, and no second request is serviced.
  - A back-to-back request in the `ready` cycle is serviced.

Source files
------------

// File: rtl/sa_cache_ctrl.sv
// 2-way set-associative, write-back/write-allocate cache controller (1 word per line).
// Tag/state and data arrays live here; misses are serviced over a simple valid/ready memory channel.
package cache_definition;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 10;
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int SETS   = 1 << IDX_W;
    localparam int WAYS   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic              valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
        logic              stopped;
    } cache_to_cpu_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic              valid;
    } cache_to_mem_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
    } mem_to_cache_type;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic             lru;
        logic [TAG_W-1:0] tag;
    } cache_table_type;
endpackage

module sa_cache_ctrl
    import cache_definition::*;
(
    input  logic             clk,
    input  logic             rst,
    input  cpu_to_cache_type cpu_req,
    output cache_to_cpu_type cache_res,
    output cache_to_mem_type mem_req,
    input  mem_to_cache_type mem_res
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              req_rw_q, req_rw_d;
    logic              victim_q, victim_d;
    cache_to_cpu_type  cache_res_q, cache_res_d;
    cache_to_mem_type  mem_req_q, mem_req_d;

    cache_table_type   tbl_q  [WAYS][SETS];
    logic [DATA_W-1:0] data_q [WAYS][SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    cache_table_type   ent      [WAYS];
    logic [DATA_W-1:0] way_data [WAYS];
    logic [WAYS-1:0]   hit_w;
    logic              hit, hit_way, victim_c, victim_dirty;

    logic [WAYS-1:0]   tbl_we, data_we;
    cache_table_type   tbl_wd  [WAYS];
    logic [DATA_W-1:0] data_wd [WAYS];

    assign idx = req_addr_q[IDX_W-1:0];
    assign tag = req_addr_q[ADDR_W-1:IDX_W];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            ent[w]      = tbl_q[w][idx];
            way_data[w] = data_q[w][idx];
            hit_w[w]    = ent[w].valid && (ent[w].tag == tag);
        end
    end

    assign hit     = |hit_w;
    assign hit_way = ~hit_w[0];
    // Fill an invalid way first (way 0 preferred); otherwise evict the LRU way, way 0 on a tie.
    assign victim_c     = ent[0].valid & (~ent[1].valid | (ent[1].lru & ~ent[0].lru));
    assign victim_dirty = ent[victim_c].valid & ent[victim_c].dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_rw_q    <= 1'b0;
            victim_q    <= 1'b0;
            cache_res_q <= '0;
            mem_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_rw_q    <= req_rw_d;
            victim_q    <= victim_d;
            cache_res_q <= cache_res_d;
            mem_req_q   <= mem_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (cpu_req.valid) state_d = COMPARE;
            COMPARE:    if (hit)               state_d = IDLE;
                        else if (victim_dirty) state_d = WRITE_BACK;
                        else                   state_d = ALLOCATE;
            WRITE_BACK: if (mem_res.ready) state_d = ALLOCATE;
            ALLOCATE:   if (mem_res.ready) state_d = COMPARE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        req_addr_d        = req_addr_q;
        req_data_d        = req_data_q;
        req_rw_d          = req_rw_q;
        victim_d          = victim_q;
        cache_res_d       = cache_res_q;
        cache_res_d.ready = 1'b0;
        mem_req_d         = mem_req_q;
        tbl_we            = '0;
        data_we           = '0;
        for (int w = 0; w < WAYS; w++) begin
            tbl_wd[w]  = ent[w];
            data_wd[w] = way_data[w];
        end

        unique case (state_q)
            IDLE: begin
                if (cpu_req.valid) begin
                    req_addr_d = cpu_req.addr;
                    req_data_d = cpu_req.data;
                    req_rw_d   = cpu_req.rw;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cache_res_d.ready = 1'b1;
                    tbl_we            = '1;
                    tbl_wd[0].lru     = hit_way;
                    tbl_wd[1].lru     = ~hit_way;
                    if (req_rw_q) begin
                        data_we[hit_way]      = 1'b1;
                        data_wd[hit_way]      = req_data_q;
                        tbl_wd[hit_way].dirty = 1'b1;
                    end else begin
                        cache_res_d.data = way_data[hit_way];
                    end
                end else begin
                    victim_d = victim_c;
                    if (victim_dirty)
                        mem_req_d = '{addr: {ent[victim_c].tag, idx}, data: way_data[victim_c],
                                      rw: 1'b1, valid: 1'b1};
                    else
                        mem_req_d = '{addr: req_addr_q, data: '0, rw: 1'b0, valid: 1'b1};
                end
            end
            WRITE_BACK: begin
                if (mem_res.ready)
                    mem_req_d = '{addr: req_addr_q, data: '0, rw: 1'b0, valid: 1'b1};
            end
            ALLOCATE: begin
                // LRU is left alone here; the re-compare hit sets it.
                if (mem_res.ready) begin
                    mem_req_d               = '0;
                    data_we[victim_q]       = 1'b1;
                    data_wd[victim_q]       = mem_res.data;
                    tbl_we[victim_q]        = 1'b1;
                    tbl_wd[victim_q].valid  = 1'b1;
                    tbl_wd[victim_q].dirty  = 1'b0;
                    tbl_wd[victim_q].tag    = tag;
                end
            end
            default: ;
        endcase

        cache_res_d.stopped = (state_d == WRITE_BACK) || (state_d == ALLOCATE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    tbl_q[w][s] <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++)
                if (tbl_we[w]) tbl_q[w][idx] <= tbl_wd[w];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++)
                if (data_we[w]) data_q[w][idx] <= data_wd[w];
        end
    end

    assign cache_res = cache_res_q;
    assign mem_req   = mem_req_q;
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Bench for sa_cache_ctrl: a memory model with programmable wait states plus a recency-based
// cache model and a flat "latest value per address" image predict every CPU-visible result.
module tb_sa_cache_ctrl;
    import cache_definition::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    cpu_to_cache_type cpu_req = '0;
    cache_to_cpu_type cache_res;
    cache_to_mem_type mem_req;
    mem_to_cache_type mem_res = '0;

    always #5 clk = ~clk;

    sa_cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req),
        .cache_res(cache_res), .mem_req(mem_req), .mem_res(mem_res)
    );

    typedef struct { bit rw; logic [19:0] addr; logic [15:0] data; } txn_t;

    int   checks = 0, errors = 0;
    int   wwb = 0, wal = 0, mcnt = 0, stab_err = 0;
    txn_t q_log [$];
    logic [15:0] mem    [logic [19:0]];
    logic [15:0] shadow [logic [19:0]];
    cache_to_mem_type mfirst;

    // Reference cache: per set, which ways hold which tag, dirtiness, and most-recently-used way.
    bit          mv  [1024][2];
    bit          md  [1024][2];
    logic [9:0]  mt  [1024][2];
    int          mru [1024];

    bit          e_hit, e_wb, o_to, o_rdy_stop, o_poked;
    logic [19:0] e_wba;
    logic [15:0] e_wbd, e_rd, o_rd;
    int          e_lat, e_stop, o_lat, o_stop;

    localparam logic [19:0] POKE_A = 20'h3F0AA;

    function automatic logic [15:0] mrd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] sval(input logic [19:0] a);
        return shadow.exists(a) ? shadow[a] : (a[15:0] ^ 16'h5A5A);
    endfunction

    // Memory: acknowledges after wwb/wal idle cycles; flags any field change while waiting.
    always @(negedge clk) begin
        if (!mem_req.valid) begin
            mem_res.ready = 1'b0;
            mcnt = 0;
        end else begin
            if (mcnt == 0) mfirst = mem_req;
            else if (mem_req !== mfirst) stab_err++;
            if (mcnt == (mem_req.rw ? wwb : wal)) begin
                mem_res.ready = 1'b1;
                if (mem_req.rw) begin
                    mem[mem_req.addr] = mem_req.data;
                    q_log.push_back('{1'b1, mem_req.addr, mem_req.data});
                end else begin
                    mem_res.data = mrd(mem_req.addr);
                    q_log.push_back('{1'b0, mem_req.addr, mem_res.data});
                end
                mcnt = 0;
            end else begin
                mem_res.ready = 1'b0;
                mcnt++;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            mv[i] = '{0, 0};
            md[i] = '{0, 0};
            mru[i] = -1;
        end
    endtask

    task automatic model_acc(input logic [19:0] a, input bit rw,
                             output bit hit, output bit wb, output logic [19:0] wba);
        int i, w;
        i = int'(a[9:0]);
        hit = 0; wb = 0; w = 0; wba = '0;
        for (int k = 0; k < 2; k++)
            if (mv[i][k] && mt[i][k] == a[19:10]) begin hit = 1; w = k; end
        if (!hit) begin
            if (!mv[i][0])      w = 0;
            else if (!mv[i][1]) w = 1;
            else if (mru[i] < 0) w = 0;
            else                w = 1 - mru[i];
            if (mv[i][w] && md[i][w]) begin wb = 1; wba = {mt[i][w], a[9:0]}; end
            mv[i][w] = 1; md[i][w] = 0; mt[i][w] = a[19:10];
        end
        if (rw) md[i][w] = 1;
        mru[i] = w;
    endtask

    // Predicts the outcome, then runs one CPU request; called and returning at a falling edge.
    task automatic op(input logic [19:0] a, input bit rw, input logic [15:0] d, input bit poke);
        bit h, wb;
        logic [19:0] wba;
        e_rd = sval(a);
        model_acc(a, rw, h, wb, wba);
        e_hit = h; e_wb = wb; e_wba = wba;
        e_wbd  = wb ? sval(wba) : 16'h0;
        e_stop = h ? 0 : (wal + 1) + (wb ? wwb + 1 : 0);
        e_lat  = h ? 2 : 3 + e_stop;
        if (rw) shadow[a] = d;
        q_log.delete();
        cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
        @(posedge clk);
        o_lat = 0; o_stop = 0; o_poked = 0;
        do begin
            @(negedge clk);
            cpu_req.valid = 1'b0;
            o_lat++;
            if (cache_res.ready) break;
            if (cache_res.stopped) o_stop++;
            if (poke && !o_poked && cache_res.stopped && !mem_req.rw) begin
                cpu_req = '{addr: POKE_A, data: 16'h1111, rw: 1'b1, valid: 1'b1};
                o_poked = 1;
            end
        end while (o_lat < 400);
        o_to = !cache_res.ready;
        o_rdy_stop = cache_res.stopped;
        o_rd = cache_res.data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cache_res !== '0) begin errors++; $display("FAIL reset_cache_res: got %h expected 0", cache_res); end
        checks++; if (mem_req !== '0) begin errors++; $display("FAIL reset_mem_req: got %h expected 0", mem_req); end
        rst = 1'b0;
    endtask

    task automatic test_cold_read();
        wal = 3; wwb = 0;
        op(20'h00005, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 7) begin errors++; $display("FAIL cold_lat: got %0d expected 7", o_lat); end
        checks++; if (o_rd !== 16'hBEEF) begin errors++; $display("FAIL cold_data: got %h expected beef", o_rd); end
        checks++; if (q_log.size() !== 1) begin errors++; $display("FAIL cold_txns: got %0d expected 1", q_log.size()); end
        else begin
            checks++; if (q_log[0].rw !== 1'b0 || q_log[0].addr !== 20'h00005) begin
                errors++; $display("FAIL cold_alloc: got rw=%0b addr=%h expected rw=0 addr=00005", q_log[0].rw, q_log[0].addr); end
        end
        checks++; if (o_stop !== 4) begin errors++; $display("FAIL cold_stopped: got %0d cycles expected 4", o_stop); end
        checks++; if (o_rdy_stop !== 1'b0) begin errors++; $display("FAIL cold_stop_at_ready: got 1 expected 0"); end
    endtask

    task automatic test_read_hit();
        op(20'h00005, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL hit_lat: got %0d expected 2", o_lat); end
        checks++; if (o_rd !== 16'hBEEF) begin errors++; $display("FAIL hit_data: got %h expected beef", o_rd); end
        checks++; if (q_log.size() !== 0 || o_stop !== 0) begin
            errors++; $display("FAIL hit_no_mem: got txns=%0d stopped=%0d expected 0 0", q_log.size(), o_stop); end
    endtask

    task automatic test_write_evict();
        wal = 1; wwb = 1;
        op(20'h00405, 1'b1, 16'h1234, 1'b0);
        checks++; if (o_lat !== 5 || q_log.size() !== 1) begin
            errors++; $display("FAIL wmiss: got lat=%0d txns=%0d expected 5 1", o_lat, q_log.size()); end
        op(20'h00805, 1'b0, 16'h0, 1'b0);
        checks++; if (q_log.size() !== 1 || o_lat !== 5) begin
            errors++; $display("FAIL clean_evict: got txns=%0d lat=%0d expected 1 5", q_log.size(), o_lat); end
        checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL clean_evict_data: got %h expected %h", o_rd, e_rd); end
        op(20'h00C05, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 7) begin errors++; $display("FAIL dirty_evict_lat: got %0d expected 7", o_lat); end
        checks++; if (q_log.size() !== 2) begin errors++; $display("FAIL dirty_evict_txns: got %0d expected 2", q_log.size()); end
        else begin
            checks++; if (q_log[0].rw !== 1'b1 || q_log[0].addr !== 20'h00405 || q_log[0].data !== 16'h1234) begin
                errors++; $display("FAIL dirty_wb: got rw=%0b addr=%h data=%h expected 1 00405 1234",
                                   q_log[0].rw, q_log[0].addr, q_log[0].data); end
            checks++; if (q_log[1].rw !== 1'b0 || q_log[1].addr !== 20'h00C05) begin
                errors++; $display("FAIL dirty_alloc: got rw=%0b addr=%h expected 0 00c05", q_log[1].rw, q_log[1].addr); end
        end
    endtask

    task automatic test_latency();
        wal = 0; wwb = 0;
        op(20'h01006, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL zw_lat_nowb: got %0d expected 4", o_lat); end
        op(20'h01406, 1'b1, 16'hAAAA, 1'b0);
        op(20'h00006, 1'b1, 16'hBBBB, 1'b0);
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL zw_lat_clean: got %0d expected 4", o_lat); end
        op(20'h01806, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 5) begin errors++; $display("FAIL zw_lat_wb: got %0d expected 5", o_lat); end
        checks++; if (q_log.size() < 1 || q_log[0].addr !== 20'h01406 || q_log[0].data !== 16'hAAAA) begin
            errors++; $display("FAIL zw_wb: got txns=%0d expected wb of 01406/aaaa", q_log.size()); end
        checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL zw_data: got %h expected %h", o_rd, e_rd); end
        wal = 20; wwb = 20; stab_err = 0;
        op(20'h01C06, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 45) begin errors++; $display("FAIL slow_lat: got %0d expected 45", o_lat); end
        checks++; if (o_stop !== 42) begin errors++; $display("FAIL slow_stopped: got %0d expected 42", o_stop); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_stable: got %0d changes expected 0", stab_err); end
        checks++; if (q_log.size() !== 2 || q_log[0].data !== 16'hBBBB) begin
            errors++; $display("FAIL slow_wb: got txns=%0d expected 2 with wb data bbbb", q_log.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        wal = 1; wwb = 1;
        op(20'h00405, 1'b1, 16'h5678, 1'b0);
        op(20'h00C05, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL pre_rst_hit: got %0d expected 2", o_lat); end
        wwb = 20;
        q_log.delete();
        cpu_req = '{addr: 20'h00805, data: 16'h0, rw: 1'b0, valid: 1'b1};
        @(posedge clk);
        @(negedge clk);
        cpu_req.valid = 1'b0;
        n = 0;
        while (!(mem_req.valid && mem_req.rw) && n < 20) begin @(negedge clk); n++; end
        checks++; if (!(mem_req.valid && mem_req.rw) || mem_req.addr !== 20'h00405 || mem_req.data !== 16'h5678) begin
            errors++; $display("FAIL rst_mid_wb: got valid=%0b rw=%0b addr=%h data=%h expected 1 1 00405 5678",
                               mem_req.valid, mem_req.rw, mem_req.addr, mem_req.data); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== '0) begin errors++; $display("FAIL rst_mid_mem_req: got %h expected 0", mem_req); end
        checks++; if (cache_res !== '0) begin errors++; $display("FAIL rst_mid_cache_res: got %h expected 0", cache_res); end
        checks++; if (q_log.size() !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d txns expected 0", q_log.size()); end
        rst = 1'b0;
        model_reset();
        shadow = mem;
        wal = 1; wwb = 1;
        op(20'h00405, 1'b0, 16'h0, 1'b0);
        checks++; if (q_log.size() !== 1 || o_lat !== 5) begin
            errors++; $display("FAIL post_rst_miss: got txns=%0d lat=%0d expected 1 5", q_log.size(), o_lat); end
        checks++; if (o_rd !== 16'h1234) begin errors++; $display("FAIL post_rst_data: got %h expected 1234", o_rd); end
    endtask

    task automatic test_protocol();
        int seen;
        wal = 3; wwb = 0;
        op(20'h02007, 1'b0, 16'h0, 1'b1);
        checks++; if (o_poked !== 1'b1 || q_log.size() !== 1 || o_lat !== 7) begin
            errors++; $display("FAIL poke_ignored: got poked=%0b txns=%0d lat=%0d expected 1 1 7", o_poked, q_log.size(), o_lat); end
        checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL poke_data: got %h expected %h", o_rd, e_rd); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cache_res.ready || mem_req.valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL poke_no_second: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        wal = 0; wwb = 0;
        op(20'h02007, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL b2b_hit: got %0d expected 2", o_lat); end
        op(20'h02407, 1'b1, 16'h4321, 1'b0);
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL b2b_wmiss: got %0d expected 4", o_lat); end
        op(20'h02407, 1'b0, 16'h0, 1'b0);
        checks++; if (o_lat !== 2 || o_rd !== 16'h4321) begin
            errors++; $display("FAIL b2b_readback: got lat=%0d data=%h expected 2 4321", o_lat, o_rd); end
    endtask

    task automatic test_random();
        logic [19:0] a;
        bit rw;
        for (int n = 0; n < 80; n++) begin
            a   = 20'($urandom_range(0, 7) * 1024 + 5 + $urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            wal = $urandom_range(0, 3);
            wwb = $urandom_range(0, 3);
            op(a, rw, 16'($urandom), 1'b0);
            checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", n, o_lat, e_lat); end
            checks++; if (o_stop !== e_stop || o_rdy_stop !== 1'b0) begin
                errors++; $display("FAIL rnd_stopped[%0d]: got %0d/%0b expected %0d/0", n, o_stop, o_rdy_stop, e_stop); end
            checks++; if (q_log.size() !== int'(e_wb) + int'(!e_hit)) begin
                errors++; $display("FAIL rnd_txns[%0d]: got %0d expected %0d", n, q_log.size(), int'(e_wb) + int'(!e_hit)); end
            else if (e_wb) begin
                checks++; if (q_log[0].rw !== 1'b1 || q_log[0].addr !== e_wba || q_log[0].data !== e_wbd) begin
                    errors++; $display("FAIL rnd_wb[%0d]: got %h/%h expected %h/%h", n, q_log[0].addr, q_log[0].data, e_wba, e_wbd); end
            end
            if (!rw) begin
                checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL rnd_data[%0d] @%h: got %h expected %h", n, a, o_rd, e_rd); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        mem[20'h00005]    = 16'hBEEF;
        shadow[20'h00005] = 16'hBEEF;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_evict();
        test_latency();
        test_reset_mid();
        test_protocol();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
